// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if -- request/response handshake and ALU datapath bundle for
// alu_sequencer.
//   REQ_VALID/REQ_READY/REQ_OP/REQ_A/REQ_B : request channel (B[4:0] = shift count)
//   RSP_VALID/RSP_READY/RSP_RESULT         : response channel
//   ALU_A/ALU_B/ALU_RESULT                 : operands to / result from the datapath
//   CISEL/BSEL/OSEL/SHIFT_LA/SHIFT_LR/LOGICAL_OP/ALU_EN : datapath controls
//   BUSY                                   : sequencer not idle
// The slave modport is the sequencer; the master modport is its environment
// (requester, response consumer and ALU datapath).
interface alu_sequencer_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [2:0]  REQ_OP;
  logic [31:0] REQ_A;
  logic [31:0] REQ_B;
  logic [31:0] ALU_A;
  logic [31:0] ALU_B;
  logic        CISEL;
  logic        BSEL;
  logic        SHIFT_LA;
  logic        SHIFT_LR;
  logic        LOGICAL_OP;
  logic [1:0]  OSEL;
  logic        ALU_EN;
  logic [31:0] ALU_RESULT;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_RESULT;
  logic        BUSY;

  modport master (
    output REQ_VALID, REQ_OP, REQ_A, REQ_B, RSP_READY, ALU_RESULT,
    input  REQ_READY, ALU_A, ALU_B, CISEL, BSEL, SHIFT_LA, SHIFT_LR,
           LOGICAL_OP, OSEL, ALU_EN, RSP_VALID, RSP_RESULT, BUSY
  );

  modport slave (
    input  REQ_VALID, REQ_OP, REQ_A, REQ_B, RSP_READY, ALU_RESULT,
    output REQ_READY, ALU_A, ALU_B, CISEL, BSEL, SHIFT_LA, SHIFT_LR,
           LOGICAL_OP, OSEL, ALU_EN, RSP_VALID, RSP_RESULT, BUSY
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer -- sequences one ALU operation at a time through an external
// combinational datapath. Single-pass ops take one EXEC cycle; shift ops
// (010 left, 100 logical right) iterate a shift-by-one B[4:0] times, feeding
// the partial result back into a_reg.
// Ports:
//   CLK   : clock, all state on rising edge
//   RESET : synchronous active-high reset
//   bus   : alu_sequencer_if.slave (request, response and datapath signals)
module alu_sequencer (
  input  logic             CLK,
  input  logic             RESET,
  alu_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [2:0]  op_reg, op_d;
  logic [31:0] a_reg, a_d;
  logic [31:0] b_reg, b_d;
  logic [4:0]  cnt, cnt_d;
  logic [31:0] res_reg, res_d;

  logic        op_is_shift;
  logic        req_is_shift;

  assign op_is_shift  = (op_reg == 3'b010) || (op_reg == 3'b100);
  assign req_is_shift = (bus.REQ_OP == 3'b010) || (bus.REQ_OP == 3'b100);

  // Datapath control decode, purely from the latched op.
  always_comb begin
    bus.CISEL      = 1'b1;
    bus.BSEL       = 1'b1;
    bus.OSEL       = 2'b10;
    bus.SHIFT_LA   = 1'b0;
    bus.SHIFT_LR   = 1'b1;
    bus.LOGICAL_OP = 1'b0;
    case (op_reg)
      3'b000: begin
        bus.CISEL = 1'b0;
        bus.BSEL  = 1'b0;
        bus.OSEL  = 2'b01;
      end
      3'b001: begin
        bus.OSEL  = 2'b01;
      end
      3'b010: begin
        bus.OSEL     = 2'b00;
        bus.SHIFT_LA = 1'b1;
      end
      3'b011: begin
        bus.CISEL = 1'b0;
        bus.BSEL  = 1'b0;
        bus.OSEL  = 2'b00;
      end
      3'b100: begin
        bus.OSEL     = 2'b00;
        bus.SHIFT_LR = 1'b0;
      end
      3'b101: begin
        bus.BSEL       = 1'b0;
        bus.LOGICAL_OP = 1'b1;
      end
      3'b110: begin
        bus.BSEL = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // Shifts always move by one bit per EXEC cycle.
  assign bus.ALU_A      = a_reg;
  assign bus.ALU_B      = op_is_shift ? 32'd1 : b_reg;
  assign bus.ALU_EN     = (state == EXEC);
  assign bus.REQ_READY  = (state == IDLE);
  assign bus.RSP_VALID  = (state == DONE);
  assign bus.RSP_RESULT = res_reg;
  assign bus.BUSY       = (state != IDLE);

  // Next-state and register-update logic.
  always_comb begin
    state_d = state;
    op_d    = op_reg;
    a_d     = a_reg;
    b_d     = b_reg;
    cnt_d   = cnt;
    res_d   = res_reg;
    case (state)
      IDLE: begin
        if (bus.REQ_VALID) begin
          op_d  = bus.REQ_OP;
          a_d   = bus.REQ_A;
          b_d   = bus.REQ_B;
          cnt_d = bus.REQ_B[4:0];
          // A zero-count shift is the identity: skip EXEC entirely.
          if (req_is_shift && (bus.REQ_B[4:0] == 5'd0)) begin
            res_d   = bus.REQ_A;
            state_d = DONE;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (op_is_shift) begin
          a_d   = bus.ALU_RESULT;
          cnt_d = cnt - 5'd1;
          if (cnt == 5'd1) begin
            res_d   = bus.ALU_RESULT;
            state_d = DONE;
          end
        end else begin
          res_d   = bus.ALU_RESULT;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.RSP_READY) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      op_reg  <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      cnt     <= '0;
      res_reg <= '0;
    end else begin
      state   <= state_d;
      op_reg  <= op_d;
      a_reg   <= a_d;
      b_reg   <= b_d;
      cnt     <= cnt_d;
      res_reg <= res_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer -- directed plus randomized checks of alu_sequencer against
// an operation-level reference model (result, latency, EXEC-cycle count and
// control decode per op code). The bench also plays the ALU datapath.
module tb_alu_sequencer;
  logic CLK;
  logic RESET;
  int   checks;
  int   errors;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Datapath model driven purely by the control outputs.
  always_comb begin
    bus.ALU_RESULT = bus.ALU_A | bus.ALU_B;
    if (bus.OSEL == 2'b01) begin
      bus.ALU_RESULT = bus.CISEL ? (bus.ALU_A - bus.ALU_B) : (bus.ALU_A + bus.ALU_B);
    end else if (bus.OSEL == 2'b00) begin
      if (bus.SHIFT_LA)       bus.ALU_RESULT = bus.ALU_A << bus.ALU_B[4:0];
      else if (!bus.SHIFT_LR) bus.ALU_RESULT = bus.ALU_A >> bus.ALU_B[4:0];
    end else if (bus.LOGICAL_OP) begin
      bus.ALU_RESULT = bus.ALU_A & bus.ALU_B;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a << b[4:0];
      3'b100:  return a >> b[4:0];
      3'b101:  return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic bit is_shift(input logic [2:0] op);
    return (op == 3'b010) || (op == 3'b100);
  endfunction

  // {CISEL, BSEL, OSEL[1:0], SHIFT_LA, SHIFT_LR, LOGICAL_OP}
  function automatic logic [6:0] ref_ctrl(input logic [2:0] op);
    logic       ci, bs, la, lr, lo;
    logic [1:0] os;
    ci = !(op == 3'd0 || op == 3'd3);
    bs = !(op == 3'd0 || op == 3'd3 || op == 3'd5 || op == 3'd6);
    if (op == 3'd0 || op == 3'd1)                    os = 2'b01;
    else if (op == 3'd2 || op == 3'd3 || op == 3'd4) os = 2'b00;
    else                                             os = 2'b10;
    la = (op == 3'd2);
    lr = (op != 3'd4);
    lo = (op == 3'd5);
    return {ci, bs, os, la, lr, lo};
  endfunction

  function automatic logic [6:0] obs_ctrl();
    return {bus.CISEL, bus.BSEL, bus.OSEL, bus.SHIFT_LA, bus.SHIFT_LR, bus.LOGICAL_OP};
  endfunction

  // Issue one request and follow it to completion. hold = cycles of RSP_READY=0
  // once the response is visible; during that time a spurious request is driven.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    int          k;
    int          en;
    int          exp_lat;
    int          exp_en;
    logic [31:0] exp_res;
    bit          seen;
    exp_res = ref_result(op, a, b);
    if (is_shift(op)) begin
      exp_lat = (b[4:0] == 5'd0) ? 1 : int'(b[4:0]) + 1;
      exp_en  = int'(b[4:0]);
    end else begin
      exp_lat = 2;
      exp_en  = 1;
    end
    @(negedge CLK);
    check("req_ready_idle", 32'(bus.REQ_READY), 32'd1);
    bus.REQ_VALID = 1'b1;
    bus.REQ_OP    = op;
    bus.REQ_A     = a;
    bus.REQ_B     = b;
    @(negedge CLK);
    k    = 1;
    en   = 0;
    seen = 1'b0;
    while (k <= 40) begin
      if (bus.RSP_VALID) begin
        seen = 1'b1;
        break;
      end
      check("busy_inflight", 32'(bus.BUSY), 32'd1);
      check("req_ready_inflight", 32'(bus.REQ_READY), 32'd0);
      if (bus.ALU_EN) begin
        en++;
        check("alu_b", bus.ALU_B, is_shift(op) ? 32'd1 : b);
        if (en == 1) begin
          check($sformatf("ctrl_op%0d", op), 32'(obs_ctrl()), 32'(ref_ctrl(op)));
          check("alu_a_first", bus.ALU_A, a);
        end
      end
      // Request-side noise must be ignored while busy.
      bus.REQ_VALID = 1'($urandom);
      bus.REQ_OP    = 3'($urandom);
      bus.REQ_A     = $urandom;
      bus.REQ_B     = $urandom;
      bus.RSP_READY = 1'($urandom);
      @(negedge CLK);
      k++;
    end
    check("rsp_valid_seen", 32'(seen), 32'd1);
    check("latency", 32'(k), 32'(exp_lat));
    check("exec_cycles", 32'(en), 32'(exp_en));
    check("rsp_result", bus.RSP_RESULT, exp_res);
    check("alu_en_done", 32'(bus.ALU_EN), 32'd0);
    for (int h = 0; h < hold; h++) begin
      bus.RSP_READY = 1'b0;
      bus.REQ_VALID = 1'b1;
      bus.REQ_OP    = 3'($urandom);
      bus.REQ_A     = $urandom;
      bus.REQ_B     = $urandom;
      @(negedge CLK);
      check("hold_valid", 32'(bus.RSP_VALID), 32'd1);
      check("hold_result", bus.RSP_RESULT, exp_res);
      check("hold_req_ready", 32'(bus.REQ_READY), 32'd0);
    end
    bus.REQ_VALID = 1'b0;
    bus.RSP_READY = 1'b1;
    @(negedge CLK);
    bus.RSP_READY = 1'b0;
    check("post_req_ready", 32'(bus.REQ_READY), 32'd1);
    check("post_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    check("post_busy", 32'(bus.BUSY), 32'd0);
    check("post_rsp_result", bus.RSP_RESULT, exp_res);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
    check({tag, "_req_ready"}, 32'(bus.REQ_READY), 32'd1);
    check({tag, "_rsp_valid"}, 32'(bus.RSP_VALID), 32'd0);
    check({tag, "_alu_en"}, 32'(bus.ALU_EN), 32'd0);
    check({tag, "_ctrl"}, 32'(obs_ctrl()), 32'(ref_ctrl(3'd0)));
    check({tag, "_a_reg"}, dut.a_reg, 32'd0);
    check({tag, "_rsp_result"}, bus.RSP_RESULT, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int en;
    bit leak;
    checks = 0;
    errors = 0;
    RESET         = 1'b1;
    bus.REQ_VALID = 1'b0;
    bus.REQ_OP    = '0;
    bus.REQ_A     = '0;
    bus.REQ_B     = '0;
    bus.RSP_READY = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_state("reset");
    RESET = 1'b0;

    run_op(3'b000, 32'd5, 32'd7, 0);             // add
    run_op(3'b010, 32'h1, 32'd4, 0);             // left shift
    run_op(3'b100, 32'hF0, 32'd32, 0);           // zero-count shift
    run_op(3'b001, 32'd10, 32'd3, 5);            // backpressure
    run_op(3'b100, 32'h8000_0000, 32'd31, 1);    // max count
    for (int op = 0; op < 8; op++) begin         // decode sweep
      run_op(3'(op), $urandom, 32'd1, 0);
    end

    // Reset abort at the 10th EXEC cycle of a long shift.
    @(negedge CLK);
    bus.REQ_VALID = 1'b1;
    bus.REQ_OP    = 3'b010;
    bus.REQ_A     = 32'd1;
    bus.REQ_B     = 32'd31;
    @(negedge CLK);
    bus.REQ_VALID = 1'b0;
    en = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.ALU_EN) en++;
      if (en == 10) break;
      @(negedge CLK);
    end
    check("abort_reached_exec10", 32'(en), 32'd10);
    RESET         = 1'b1;
    bus.REQ_VALID = 1'b1;
    bus.RSP_READY = 1'b1;
    @(negedge CLK);
    RESET         = 1'b0;
    bus.REQ_VALID = 1'b0;
    bus.RSP_READY = 1'b0;
    check_reset_state("abort");
    leak = 1'b0;
    repeat (35) begin
      @(negedge CLK);
      if (bus.RSP_VALID) leak = 1'b1;
    end
    check("abort_no_response", 32'(leak), 32'd0);
    run_op(3'b000, 32'd1, 32'd1, 0);

    // Reset in DONE with a simultaneous RSP_READY and REQ_VALID.
    @(negedge CLK);
    bus.REQ_VALID = 1'b1;
    bus.REQ_OP    = 3'b101;
    bus.REQ_A     = 32'hFFFF_0000;
    bus.REQ_B     = 32'h0F0F_0F0F;
    @(negedge CLK);
    bus.REQ_VALID = 1'b0;
    @(negedge CLK);
    check("done_before_reset", 32'(bus.RSP_VALID), 32'd1);
    RESET         = 1'b1;
    bus.RSP_READY = 1'b1;
    bus.REQ_VALID = 1'b1;
    @(negedge CLK);
    RESET         = 1'b0;
    bus.RSP_READY = 1'b0;
    bus.REQ_VALID = 1'b0;
    check_reset_state("done_abort");

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] b;
      op = 3'($urandom);
      b  = $urandom;
      if ($urandom_range(0, 3) != 0) b[4:0] = 5'($urandom_range(0, 6));
      run_op(op, $urandom, b, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
